// File: rtl/can_tx_arbiter.sv
// Frame-atomic round-robin arbiter feeding the CAN TX FIFO write port.
// A granted source owns the FIFO until its last byte; tails beyond MAXLEN are swallowed.
module can_tx_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8,
    parameter int MAXLEN = 72,
    parameter int CWIDTH = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic                     ot_valid,
    input  logic                     ot_ready,
    output logic [DWIDTH-1:0]        ot_data,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overlen
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_XFER    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]         r_state;
    logic [NREQ-1:0]    r_grant;
    logic [IW-1:0]      r_gidx;
    logic [IW-1:0]      r_rr_ptr;
    logic [CWIDTH-1:0]  r_count;
    logic               r_frame_done;
    logic               r_overlen;

    logic [DWIDTH-1:0]  w_data_arr [NREQ];
    logic [IW:0]        w_cand_sum;
    logic               w_sel_found;
    logic [IW-1:0]      w_sel_idx;
    logic [NREQ-1:0]    w_sel_onehot;
    logic [IW-1:0]      w_next_ptr;
    logic [CWIDTH-1:0]  w_count_inc;
    logic               w_xfer;
    logic               w_discard;
    logic               w_beat;
    logic               w_g_last;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign w_data_arr[gi] = req_data[gi*DWIDTH +: DWIDTH];
            assign req_ready[gi]  = r_grant[gi] & ((w_xfer & ot_ready) | w_discard);
        end
    endgenerate

    // Scan downward in offset so the smallest offset from the pointer wins.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_cand_sum  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
            if (w_cand_sum >= (IW+1)'(NREQ)) begin
                w_cand_sum = w_cand_sum - (IW+1)'(NREQ);
            end
            if (req_valid[w_cand_sum[IW-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand_sum[IW-1:0];
            end
        end
    end

    assign w_sel_onehot = NREQ'(1) << w_sel_idx;
    assign w_next_ptr   = (r_gidx == IW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;
    assign w_count_inc  = r_count + 1'b1;
    assign w_xfer       = (r_state == S_XFER);
    assign w_discard    = (r_state == S_DISCARD);
    assign w_beat       = req_valid[r_gidx] & ((w_xfer & ot_ready) | w_discard);
    assign w_g_last     = req_last[r_gidx];

    assign busy       = w_xfer | w_discard;
    assign ot_valid   = w_xfer & req_valid[r_gidx];
    assign ot_data    = busy ? w_data_arr[r_gidx] : '0;
    assign grant      = r_grant;
    assign frame_done = r_frame_done;
    assign overlen    = r_overlen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_rr_ptr     <= '0;
            r_count      <= '0;
            r_frame_done <= 1'b0;
            r_overlen    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_overlen    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_found) begin
                        r_grant <= w_sel_onehot;
                        r_gidx  <= w_sel_idx;
                        r_count <= '0;
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_beat) begin
                        r_count <= w_count_inc;
                        if (w_g_last) begin
                            r_state      <= S_IDLE;
                            r_grant      <= '0;
                            r_rr_ptr     <= w_next_ptr;
                            r_frame_done <= 1'b1;
                        end else if (w_count_inc == CWIDTH'(MAXLEN)) begin
                            r_state   <= S_DISCARD;
                            r_overlen <= 1'b1;
                        end
                    end
                end
                S_DISCARD: begin
                    if (w_beat && w_g_last) begin
                        r_state  <= S_IDLE;
                        r_grant  <= '0;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Directed bench for can_tx_arbiter: a cycle table for the basic handshake
// plus hand-written sequences for fairness, overlength, exact max and reset.
module tb_can_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        ot_valid;
    logic        ot_ready;
    logic [7:0]  ot_data;
    logic [3:0]  grant;
    logic        busy;
    logic        frame_done;
    logic        overlen;

    int n_checks = 0;
    int n_fail   = 0;

    can_tx_arbiter #(.NREQ(4), .DWIDTH(8), .MAXLEN(72), .CWIDTH(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_last   (req_last),
        .ot_valid   (ot_valid),
        .ot_ready   (ot_ready),
        .ot_data    (ot_data),
        .grant      (grant),
        .busy       (busy),
        .frame_done (frame_done),
        .overlen    (overlen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic        rdy;
        logic [31:0] data;
        logic [3:0]  e_grant;
        logic        e_busy;
        logic        e_ovld;
        logic [3:0]  e_rrdy;
        logic [7:0]  e_odata;
        logic        e_fd;
        logic        e_ov;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] lst, input logic rdy,
                                input logic [31:0] data, input logic [3:0] g, input logic b,
                                input logic ov_v, input logic [3:0] rr, input logic [7:0] od,
                                input logic fd, input logic ol);
        vec_t v;
        v.vld = vld; v.lst = lst; v.rdy = rdy; v.data = data;
        v.e_grant = g; v.e_busy = b; v.e_ovld = ov_v; v.e_rrdy = rr;
        v.e_odata = od; v.e_fd = fd; v.e_ov = ol;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic b,
                              input logic ov_v, input logic [3:0] rr, input logic [7:0] od,
                              input logic fd, input logic ol);
        chk({tag, ".grant"},      32'(grant),      32'(g));
        chk({tag, ".busy"},       32'(busy),       32'(b));
        chk({tag, ".ot_valid"},   32'(ot_valid),   32'(ov_v));
        chk({tag, ".req_ready"},  32'(req_ready),  32'(rr));
        chk({tag, ".ot_data"},    32'(ot_data),    32'(od));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(fd));
        chk({tag, ".overlen"},    32'(overlen),    32'(ol));
    endtask

    task automatic drive(input logic [3:0] vld, input logic [3:0] lst, input logic rdy,
                         input logic [31:0] data);
        req_valid = vld;
        req_last  = lst;
        ot_ready  = rdy;
        req_data  = data;
    endtask

    logic [3:0] rr_exp_g [15];
    int         rr_exp_i [15];
    int         cnt [4];

    initial begin
        rst = 1'b1;
        drive(4'h0, 4'h0, 1'b0, 32'h0);

        // Table: single frame, rr pointer advance, backpressure frame.
        tbl[0]  = mk(4'h1, 4'h0, 1, 32'h00000010, 4'h0, 0, 0, 4'h0, 8'h00, 0, 0);
        tbl[1]  = mk(4'h1, 4'h0, 1, 32'h00000010, 4'h1, 1, 1, 4'h1, 8'h10, 0, 0);
        tbl[2]  = mk(4'h1, 4'h0, 1, 32'h00000011, 4'h1, 1, 1, 4'h1, 8'h11, 0, 0);
        tbl[3]  = mk(4'h1, 4'h0, 1, 32'h00000012, 4'h1, 1, 1, 4'h1, 8'h12, 0, 0);
        tbl[4]  = mk(4'h1, 4'h0, 1, 32'h00000013, 4'h1, 1, 1, 4'h1, 8'h13, 0, 0);
        tbl[5]  = mk(4'h1, 4'h1, 1, 32'h00000014, 4'h1, 1, 1, 4'h1, 8'h14, 0, 0);
        tbl[6]  = mk(4'h0, 4'h0, 1, 32'h00000000, 4'h0, 0, 0, 4'h0, 8'h00, 1, 0);
        tbl[7]  = mk(4'h0, 4'h0, 1, 32'h00000000, 4'h0, 0, 0, 4'h0, 8'h00, 0, 0);
        tbl[8]  = mk(4'h3, 4'h3, 0, 32'h0000B0A0, 4'h0, 0, 0, 4'h0, 8'h00, 0, 0);
        tbl[9]  = mk(4'h3, 4'h3, 0, 32'h0000B0A0, 4'h2, 1, 1, 4'h0, 8'hB0, 0, 0);
        tbl[10] = mk(4'h3, 4'h3, 1, 32'h0000B0A0, 4'h2, 1, 1, 4'h2, 8'hB0, 0, 0);
        tbl[11] = mk(4'h3, 4'h3, 1, 32'h0000B0A0, 4'h0, 0, 0, 4'h0, 8'h00, 1, 0);
        tbl[12] = mk(4'h3, 4'h3, 1, 32'h0000B0A0, 4'h1, 1, 1, 4'h1, 8'hA0, 0, 0);
        tbl[13] = mk(4'h0, 4'h0, 1, 32'h00000000, 4'h0, 0, 0, 4'h0, 8'h00, 1, 0);
        tbl[14] = mk(4'h8, 4'h0, 1, 32'h30000000, 4'h0, 0, 0, 4'h0, 8'h00, 0, 0);
        tbl[15] = mk(4'h8, 4'h0, 1, 32'h30000000, 4'h8, 1, 1, 4'h8, 8'h30, 0, 0);
        tbl[16] = mk(4'h8, 4'h0, 0, 32'h31000000, 4'h8, 1, 1, 4'h0, 8'h31, 0, 0);
        tbl[17] = mk(4'h8, 4'h0, 0, 32'h31000000, 4'h8, 1, 1, 4'h0, 8'h31, 0, 0);
        tbl[18] = mk(4'h8, 4'h0, 1, 32'h31000000, 4'h8, 1, 1, 4'h8, 8'h31, 0, 0);
        tbl[19] = mk(4'h8, 4'h0, 1, 32'h32000000, 4'h8, 1, 1, 4'h8, 8'h32, 0, 0);
        tbl[20] = mk(4'h8, 4'h8, 1, 32'h33000000, 4'h8, 1, 1, 4'h8, 8'h33, 0, 0);
        tbl[21] = mk(4'h0, 4'h0, 1, 32'h00000000, 4'h0, 0, 0, 4'h0, 8'h00, 1, 0);

        rr_exp_g = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4,
                     4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
        rr_exp_i = '{-1, 0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0, 0};

        @(negedge clk);
        #1;
        check_outs("reset", 4'h0, 0, 0, 4'h0, 8'h00, 0, 0);
        $display("reset: outputs checked");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].vld, tbl[i].lst, tbl[i].rdy, tbl[i].data);
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].e_grant, tbl[i].e_busy, tbl[i].e_ovld,
                       tbl[i].e_rrdy, tbl[i].e_odata, tbl[i].e_fd, tbl[i].e_ov);
            $display("vec %0d: vld=%h rdy=%b grant=%h ot_valid=%b ot_data=%h",
                     i, tbl[i].vld, tbl[i].rdy, grant, ot_valid, ot_data);
            @(negedge clk);
        end

        // Round-robin: all four present 2-byte frames back to back; pointer starts at 0.
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 15; c++) begin
            req_valid = 4'hF;
            ot_ready  = 1'b1;
            for (int i = 0; i < 4; i++) begin
                req_data[i*8 +: 8] = 8'((i << 4) | cnt[i]);
                req_last[i]        = (cnt[i] == 1);
            end
            #1;
            chk($sformatf("rr%0d.grant", c), 32'(grant), 32'(rr_exp_g[c]));
            if (rr_exp_i[c] >= 0) begin
                chk($sformatf("rr%0d.ot_data", c), 32'(ot_data),
                    32'((rr_exp_i[c] << 4) | cnt[rr_exp_i[c]]));
                if (cnt[rr_exp_i[c]] == 1)
                    $display("rr frame from requester %0d complete", rr_exp_i[c]);
                cnt[rr_exp_i[c]] = cnt[rr_exp_i[c]] ^ 1;
            end
            @(negedge clk);
        end
        drive(4'h0, 4'h0, 1'b1, 32'h0);
        @(negedge clk);

        // Overlength: requester 2 sends 75 bytes; pointer is at 1.
        drive(4'h4, 4'h0, 1'b1, 32'h00010000);
        #1;
        chk("ovl.idle_grant", 32'(grant), 32'h0);
        @(negedge clk);
        for (int k = 1; k <= 75; k++) begin
            drive(4'h4, (k == 75) ? 4'h4 : 4'h0, 1'b1, 32'(k) << 16);
            #1;
            chk($sformatf("ovl%0d.grant", k), 32'(grant), 32'h4);
            chk($sformatf("ovl%0d.req_ready", k), 32'(req_ready), 32'h4);
            chk($sformatf("ovl%0d.overlen", k), 32'(overlen), 32'(k == 73));
            chk($sformatf("ovl%0d.frame_done", k), 32'(frame_done), 32'h0);
            if (k <= 72) begin
                chk($sformatf("ovl%0d.ot_valid", k), 32'(ot_valid), 32'h1);
                chk($sformatf("ovl%0d.ot_data", k), 32'(ot_data), 32'(k));
            end else begin
                chk($sformatf("ovl%0d.ot_valid", k), 32'(ot_valid), 32'h0);
            end
            @(negedge clk);
        end
        drive(4'h9, 4'h9, 1'b1, 32'hD00000C0);
        #1;
        check_outs("ovl.after", 4'h0, 0, 0, 4'h0, 8'h00, 0, 0);
        @(negedge clk);
        #1;
        check_outs("ovl.next", 4'h8, 1, 1, 4'h8, 8'hD0, 0, 0);
        $display("overlength frame: 72 forwarded, 3 dropped, next grant=%h", grant);
        @(negedge clk);
        drive(4'h0, 4'h0, 1'b1, 32'h0);
        @(negedge clk);

        // Exact max: requester 0 (pointer now 0) sends 72 bytes with last on 72.
        drive(4'h1, 4'h0, 1'b1, 32'h1);
        @(negedge clk);
        for (int k = 1; k <= 72; k++) begin
            drive(4'h1, (k == 72) ? 4'h1 : 4'h0, 1'b1, 32'(k));
            #1;
            chk($sformatf("max%0d.ot_valid", k), 32'(ot_valid), 32'h1);
            chk($sformatf("max%0d.ot_data", k), 32'(ot_data), 32'(k));
            chk($sformatf("max%0d.overlen", k), 32'(overlen), 32'h0);
            @(negedge clk);
        end
        drive(4'h0, 4'h0, 1'b1, 32'h0);
        #1;
        check_outs("max.done", 4'h0, 0, 0, 4'h0, 8'h00, 1, 0);
        $display("exact-max frame: frame_done=%b overlen=%b", frame_done, overlen);
        @(negedge clk);

        // Reset mid-frame: requester 1 (pointer now 1) after three accepted bytes.
        drive(4'h2, 4'h0, 1'b1, 32'h00000100);
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            drive(4'h2, 4'h0, 1'b1, 32'(k) << 8);
            #1;
            chk($sformatf("rst_pre%0d.grant", k), 32'(grant), 32'h2);
            @(negedge clk);
        end
        drive(4'h2, 4'h0, 1'b1, 32'h00000400);
        rst = 1'b1;
        #1;
        chk("rst_mid.grant", 32'(grant), 32'h0);
        chk("rst_mid.busy", 32'(busy), 32'h0);
        chk("rst_mid.ot_valid", 32'(ot_valid), 32'h0);
        chk("rst_mid.req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'h3, 4'h3, 1'b1, 32'h0000B1A1);
        #1;
        chk("rst_post.idle_grant", 32'(grant), 32'h0);
        @(negedge clk);
        #1;
        check_outs("rst_post", 4'h1, 1, 1, 4'h1, 8'hA1, 0, 0);
        $display("reset mid-frame: post-reset grant=%h", grant);
        @(negedge clk);
        drive(4'h0, 4'h0, 1'b0, 32'h0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/can_tx_arbiter.md
# can_tx_arbiter

Frame-atomic round-robin arbiter that lets up to NREQ transmit sources share the single write port of the CAN TX FIFO. A source keeps the grant from its first byte until it presents its `last` byte, so bytes from different frames never interleave in the FIFO. The block sits between the host-side frame builders and the TX FIFO input handshake (valid/ready/data). It also enforces a maximum frame length and discards any overrunning tail.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DWIDTH`, 8: byte width; matches the TX FIFO data width.
- `MAXLEN`, 72: maximum bytes per frame (CAN FD header plus 64 data bytes).
- `CWIDTH`, 7: byte counter width; must satisfy 2^CWIDTH > MAXLEN.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester byte valid.
- `req_ready`  out  NREQ  per-requester byte accept.
- `req_data`  in  NREQ*DWIDTH  requester i occupies bits [i*DWIDTH +: DWIDTH].
- `req_last`  in  NREQ  marks the final byte of the frame; qualified by valid.
- `ot_valid`  out  1  to the FIFO `itvalid` input.
- `ot_ready`  in  1  from the FIFO `itready` output.
- `ot_data`  out  DWIDTH  to the FIFO `itdata` input.
- `grant`  out  NREQ  one-hot registered grant; all zero when idle.
- `busy`  out  1  high in the XFER and DISCARD states.
- `frame_done`  out  1  one-cycle pulse after a frame's `last` byte is accepted.
- `overlen`  out  1  one-cycle pulse on entering DISCARD.

## Operation
- **States.** The block has three states: IDLE, XFER and DISCARD. Reset enters IDLE.
- **Reset values.** Reset forces the following:
  - `grant`=0 and rr pointer=0.
  - count=0 and state=IDLE.
  - `frame_done`=0 and `overlen`=0.
  - All outputs are low: `ot_valid`=0, `req_ready`=0, `busy`=0, and `ot_data`=0 (driven 0 when no grant).
- **IDLE.** `req_ready`=0 and `ot_valid`=0.
  - If any `req_valid` is high, select the first requester found scanning upward from the rr pointer, wrapping from NREQ-1 to 0.
  - Register the selection as a one-hot `grant`, set count=0 and go to XFER.
- **XFER (grant g).** The handshake is combinational pass-through:
  - `ot_valid`=`req_valid[g]`, `ot_data`=`req_data[g]`, `req_ready[g]`=`ot_ready`.
  - All other `req_ready` bits are 0.
  - A beat is accepted when `req_valid[g]` and `ot_ready` are both high; each accepted beat increments count.
- **XFER exits.** Checked on every accepted beat:
  - Accepted beat with `req_last[g]`=1: go to IDLE, clear `grant`, set rr pointer to g+1 mod NREQ, and pulse `frame_done` in the next cycle.
  - Accepted beat with `req_last`=0 that makes count=MAXLEN: go to DISCARD and pulse `overlen` in the next cycle.
  - A beat with `req_last`=1 that makes count equal MAXLEN is a normal completion.
- **DISCARD.** `ot_valid`=0 and `req_ready[g]`=1. Incoming bytes are dropped.
  - On an accepted `req_last[g]`, go to IDLE, advance the rr pointer as above, and clear `grant`.
  - `frame_done` does not pulse for a discarded frame.
- **Grant hold.** If `req_valid[g]` drops mid-frame, the grant is held indefinitely; no other requester is served until `last`.
- **Arithmetic.** count is CWIDTH bits, compared against MAXLEN with an exact-equality test, and never wraps.

## Timing
- Arbitration takes 1 cycle: a request seen in IDLE at cycle n gives `grant` and `busy` high at n+1, and the first byte can transfer at n+1.
- Back-to-back frames: `last` accepted at cycle m gives IDLE at m+1 and a new grant at m+2. This is exactly one dead cycle per frame.
- The ready/valid path through XFER is zero-latency combinational. It introduces no extra register stage ahead of the FIFO.
- FIFO full (`ot_ready`=0): the granted requester stalls with no loss, and count does not advance.
- `frame_done` and `overlen` are registered pulses that are high for exactly one cycle.
- Asserting `rst` mid-frame immediately clears all state and outputs. The FIFO may hold a partial frame; clearing it is the host's responsibility.

## Test plan
- **Single frame.** Stimulus: requester 0 sends 5 bytes 0x10..0x14, last on 0x14, with `ot_ready`=1. Required response:
  - `grant`=0001 one cycle after `req_valid` rises.
  - 5 `ot` beats with identical data.
  - `frame_done` pulses 1 cycle after 0x14.
  - rr pointer becomes 1.
- **Round-robin fairness.** Stimulus: all 4 requesters present continuous 2-byte frames. Required response:
  - Grant order is 0, 1, 2, 3, 0.
  - One idle cycle between frames.
  - No byte interleaving.
- **FIFO backpressure.** Stimulus: `ot_ready` toggles 1,0,0,1 during a 4-byte frame. Required response:
  - `req_ready[g]` mirrors `ot_ready`.
  - All 4 bytes arrive in order.
  - count reaches 4, then `frame_done` pulses.
- **Overlength.** Stimulus: with MAXLEN=72, requester 2 sends 75 bytes with last on byte 75. Required response:
  - 72 bytes are forwarded, then `overlen` pulses.
  - Bytes 73..75 are consumed with `ot_valid`=0.
  - No `frame_done`.
  - The next grant goes to requester 3.
- **Exact max.** Stimulus: a 72-byte frame with last on byte 72. Required response: `frame_done` pulses and `overlen` never pulses.
- **Reset mid-frame.** Stimulus: assert `rst` after byte 3 of a frame from requester 1. Required response:
  - In the same cycle: `grant`=0, `busy`=0, `ot_valid`=0.
  - After release, the pointer is 0 and requester 0 wins a simultaneous 0/1 request.
